// File: rtl/noc_filereg_pkg.sv
// Shared types and constants for the NoC filereg <-> AXI-Stream bridge.
package noc_filereg_pkg;

  localparam int FREG_REQ_W  = 39;
  localparam int FREG_RSP_W  = 43;
  localparam int FREG_ADDR_W = 6;
  localparam int FREG_DATA_W = 32;

  localparam int HDR_OP_BIT   = 31;
  localparam int HDR_ADDR_MSB = 30;
  localparam int HDR_ADDR_LSB = 25;

  typedef struct packed {
    logic                   op;
    logic [FREG_ADDR_W-1:0] addr;
    logic [FREG_DATA_W-1:0] wdata;
  } freg_req_t;

  typedef struct packed {
    logic                   err;
    logic [3:0]             rsvd;
    logic [FREG_ADDR_W-1:0] addr;
    logic [FREG_DATA_W-1:0] rdata;
  } freg_rsp_t;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_DATA,
    ST_FLUSH,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_RSP_HDR,
    ST_RSP_DATA
  } state_e;

  function automatic logic [31:0] rsp_header(logic err, logic [FREG_ADDR_W-1:0] addr);
    return {err, addr, 25'b0};
  endfunction

endpackage

// File: rtl/noc_filereg_axis_bridge.sv
// Bridges 2-beat AXI-Stream request frames to a router filereg port and
// returns read responses as 2-beat frames to the requesting tile.
//
// state       | meaning
// ST_HDR      | waiting for header beat (op/addr/tid)
// ST_DATA     | waiting for wdata beat, must carry tlast
// ST_FLUSH    | discarding an over-long frame up to tlast
// ST_ISSUE    | holding request on the filereg port
// ST_WAIT_RSP | read issued, waiting for router response
// ST_RSP_HDR  | sending response header beat
// ST_RSP_DATA | sending response data beat (tlast)
module noc_filereg_axis_bridge
  import noc_filereg_pkg::*;
#(
  parameter int AXIStreamTDataWidth = 32,
  parameter int AXIStreamTIdWidth   = 5,
  parameter int AXIStreamTDestWidth = 5,
  parameter int LocalTileId         = 0
) (
  input  logic                           clk_network_i,
  input  logic                           rst_network_i,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  input  logic [AXIStreamTDataWidth-1:0] s_axis_tdata,
  input  logic [AXIStreamTIdWidth-1:0]   s_axis_tid,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic [AXIStreamTDataWidth-1:0] m_axis_tdata,
  output logic [AXIStreamTIdWidth-1:0]   m_axis_tid,
  output logic [AXIStreamTDestWidth-1:0] m_axis_tdest,
  output logic                           freg_req_valid_o,
  input  logic                           freg_req_ready_i,
  output logic [FREG_REQ_W-1:0]          freg_req_data_o,
  input  logic                           freg_rsp_valid_i,
  output logic                           freg_rsp_ready_o,
  input  logic [FREG_RSP_W-1:0]          freg_rsp_data_i,
  output logic                           drop_o
);

  state_e                   state;
  freg_req_t                req_q;
  freg_rsp_t                rsp_in;
  logic [AXIStreamTIdWidth-1:0] tid_q;
  logic [FREG_DATA_W-1:0]   rdata_q;
  logic [FREG_DATA_W-1:0]   m_data_q;
  logic                     s_beat;
  logic                     rsp_beat;
  logic                     m_beat;
  logic                     unused_bits;

  assign rsp_in          = freg_rsp_data_i;
  assign s_beat          = s_axis_tvalid & s_axis_tready;
  assign rsp_beat        = freg_rsp_valid_i & freg_rsp_ready_o;
  assign m_beat          = m_axis_tvalid & m_axis_tready;
  assign freg_req_data_o = req_q;
  assign m_axis_tid      = AXIStreamTIdWidth'(LocalTileId);
  assign unused_bits     = ^{rsp_in.rsvd, s_axis_tdata};

  always_comb begin
    m_axis_tdata = '0;
    m_axis_tdata[FREG_DATA_W-1:0] = m_data_q;
  end

  always_ff @(posedge clk_network_i) begin
    if (rst_network_i) begin
      state            <= ST_HDR;
      s_axis_tready    <= 1'b1;
      freg_req_valid_o <= 1'b0;
      freg_rsp_ready_o <= 1'b1;
      m_axis_tvalid    <= 1'b0;
      m_axis_tlast     <= 1'b0;
      m_axis_tdest     <= '0;
      m_data_q         <= '0;
      drop_o           <= 1'b0;
      req_q            <= '0;
      tid_q            <= '0;
      rdata_q          <= '0;
    end else begin
      // Any response taken while no read is outstanding is discarded.
      drop_o <= rsp_beat && (state != ST_WAIT_RSP);
      unique case (state)
        ST_HDR: if (s_beat) begin
          req_q.op   <= s_axis_tdata[HDR_OP_BIT];
          req_q.addr <= s_axis_tdata[HDR_ADDR_MSB:HDR_ADDR_LSB];
          tid_q      <= s_axis_tid;
          if (s_axis_tlast) drop_o <= 1'b1;
          else              state  <= ST_DATA;
        end
        ST_DATA: if (s_beat) begin
          req_q.wdata <= s_axis_tdata[FREG_DATA_W-1:0];
          if (s_axis_tlast) begin
            state            <= ST_ISSUE;
            s_axis_tready    <= 1'b0;
            freg_req_valid_o <= 1'b1;
          end else begin
            drop_o <= 1'b1;
            state  <= ST_FLUSH;
          end
        end
        ST_FLUSH: if (s_beat && s_axis_tlast) state <= ST_HDR;
        ST_ISSUE: if (freg_req_ready_i) begin
          freg_req_valid_o <= 1'b0;
          if (req_q.op) begin
            state         <= ST_HDR;
            s_axis_tready <= 1'b1;
          end else begin
            state <= ST_WAIT_RSP;
          end
        end
        ST_WAIT_RSP: if (rsp_beat) begin
          state            <= ST_RSP_HDR;
          freg_rsp_ready_o <= 1'b0;
          m_axis_tvalid    <= 1'b1;
          m_axis_tlast     <= 1'b0;
          m_data_q         <= rsp_header(rsp_in.err, rsp_in.addr);
          m_axis_tdest     <= AXIStreamTDestWidth'(tid_q);
          rdata_q          <= rsp_in.rdata;
        end
        ST_RSP_HDR: if (m_beat) begin
          state        <= ST_RSP_DATA;
          m_data_q     <= rdata_q;
          m_axis_tlast <= 1'b1;
        end
        ST_RSP_DATA: if (m_beat) begin
          state            <= ST_HDR;
          m_axis_tvalid    <= 1'b0;
          m_axis_tlast     <= 1'b0;
          m_data_q         <= '0;
          s_axis_tready    <= 1'b1;
          freg_rsp_ready_o <= 1'b1;
        end
        default: state <= ST_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_filereg_axis_bridge.sv
// Directed + randomized bench for noc_filereg_axis_bridge with a frame-level reference model.
module tb_noc_filereg_axis_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_last;
  logic        s_axis_tready;
  logic [31:0] s_data;
  logic [4:0]  s_tid;
  logic        m_axis_tvalid, m_axis_tlast;
  logic        m_ready;
  logic [31:0] m_axis_tdata;
  logic [4:0]  m_axis_tid, m_axis_tdest;
  logic        freg_req_valid_o, freg_rsp_ready_o, drop_o;
  logic        req_ready, rsp_valid;
  logic [38:0] freg_req_data_o;
  logic [42:0] rsp_data;

  int          n_pass = 0;
  int          n_total = 0;
  int          drop_cnt = 0;
  int          req_cnt = 0;
  logic [38:0] req_seen = '0;
  logic [41:0] mq[$];

  noc_filereg_axis_bridge dut (
    .clk_network_i   (clk),
    .rst_network_i   (rst),
    .s_axis_tvalid   (s_valid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tlast    (s_last),
    .s_axis_tdata    (s_data),
    .s_axis_tid      (s_tid),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_ready),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tid      (m_axis_tid),
    .m_axis_tdest    (m_axis_tdest),
    .freg_req_valid_o(freg_req_valid_o),
    .freg_req_ready_i(req_ready),
    .freg_req_data_o (freg_req_data_o),
    .freg_rsp_valid_i(rsp_valid),
    .freg_rsp_ready_o(freg_rsp_ready_o),
    .freg_rsp_data_i (rsp_data),
    .drop_o          (drop_o)
  );

  always #5 clk = ~clk;

  // Inputs change just after posedge; handshakes are observed at negedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (drop_o) drop_cnt++;
      if (freg_req_valid_o && req_ready) begin
        req_cnt++;
        req_seen = freg_req_data_o;
      end
      if (m_axis_tvalid && m_ready)
        mq.push_back({4'b0, m_axis_tlast, m_axis_tdest, m_axis_tdata});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last, input logic [4:0] id);
    int k;
    k = 0;
    s_valid = 1'b1; s_data = d; s_last = last; s_tid = id;
    @(negedge clk);
    while (!s_axis_tready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("s_tready_timeout", 64'd0, 64'd1);
    step();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  // kind: 0 = well-formed 2-beat frame, 1 = tlast on header, 2 = 4-beat frame
  task automatic do_txn(input logic op, input logic [5:0] addr, input logic [31:0] wdata,
                        input logic [4:0] id, input int kind, input int req_delay,
                        input logic err, input logic [31:0] rdata, input int m_stall,
                        input bit m_rand, input logic [24:0] junk);
    logic [31:0] hdr, rsp_hdr, prev_data;
    logic [38:0] exp_req;
    logic [41:0] exp_q[$];
    logic        prev_stall, prev_last;
    logic [4:0]  prev_dest;
    int          d0, r0, k;
    d0 = drop_cnt; r0 = req_cnt; mq.delete();
    hdr     = (32'(op) << 31) | (32'(addr) << 25) | 32'(junk);
    exp_req = (39'(op) << 38) | (39'(addr) << 32) | 39'(wdata);
    rsp_hdr = (32'(err) << 31) | (32'(addr) << 25);
    if (kind == 1) begin
      send_beat(hdr, 1'b1, id);
    end else if (kind == 2) begin
      send_beat(hdr, 1'b0, id);
      send_beat(wdata, 1'b0, id);
      send_beat($urandom, 1'b0, id);
      send_beat($urandom, 1'b1, id);
    end else begin
      send_beat(hdr, 1'b0, id);
      send_beat(wdata, 1'b1, id);
      @(negedge clk);
      chk("req_valid_latency", 64'(freg_req_valid_o), 64'd1);
      chk("req_data", 64'(freg_req_data_o), 64'(exp_req));
      for (int i = 0; i < req_delay; i++) begin
        step();
        @(negedge clk);
        chk("req_hold_valid", 64'(freg_req_valid_o), 64'd1);
        chk("req_hold_data", 64'(freg_req_data_o), 64'(exp_req));
        chk("s_tready_issue", 64'(s_axis_tready), 64'd0);
      end
      step(); req_ready = 1'b1;
      step(); req_ready = 1'b0;
      @(negedge clk);
      chk("req_valid_after_hs", 64'(freg_req_valid_o), 64'd0);
      if (!op) begin
        exp_q.push_back({4'b0, 1'b0, id, rsp_hdr});
        exp_q.push_back({4'b0, 1'b1, id, rdata});
        chk("s_tready_wait", 64'(s_axis_tready), 64'd0);
        step();
        rsp_valid = 1'b1;
        rsp_data  = {err, 4'($urandom), addr, rdata};
        step();
        rsp_valid = 1'b0;
        prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0; prev_dest = '0;
        k = 0;
        while (mq.size() < 2 && k < 100) begin
          m_ready = (k < m_stall) ? 1'b0 : (m_rand ? 1'($urandom) : 1'b1);
          @(negedge clk);
          if (prev_stall) begin
            chk("m_hold_valid", 64'(m_axis_tvalid), 64'd1);
            chk("m_hold_data", 64'(m_axis_tdata), 64'(prev_data));
            chk("m_hold_last", 64'(m_axis_tlast), 64'(prev_last));
            chk("m_hold_dest", 64'(m_axis_tdest), 64'(prev_dest));
          end
          chk("s_tready_rsp", 64'(s_axis_tready), 64'd0);
          prev_stall = m_axis_tvalid && !m_ready;
          prev_data  = m_axis_tdata;
          prev_last  = m_axis_tlast;
          prev_dest  = m_axis_tdest;
          step();
          k++;
        end
        m_ready = 1'b0;
        if (k >= 100) chk("m_frame_timeout", 64'd0, 64'd1);
      end
    end
    repeat (2) step();
    @(negedge clk);
    chk("idle_s_tready", 64'(s_axis_tready), 64'd1);
    chk("idle_m_valid", 64'(m_axis_tvalid), 64'd0);
    chk("idle_req_valid", 64'(freg_req_valid_o), 64'd0);
    step();
    chk("drop_count", 64'(drop_cnt - d0), (kind != 0) ? 64'd1 : 64'd0);
    chk("req_count", 64'(req_cnt - r0), (kind == 0) ? 64'd1 : 64'd0);
    if (kind == 0) chk("req_seen", 64'(req_seen), 64'(exp_req));
    chk("m_beat_count", 64'(mq.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < mq.size(); i++)
      chk("m_beat", 64'(mq[i]), 64'(exp_q[i]));
  endtask

  initial begin
    int d0, r0, r, kind;
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; s_tid = '0;
    m_ready = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    repeat (2) step();
    @(negedge clk);
    chk("rst_s_tready", 64'(s_axis_tready), 64'd1);
    chk("rst_req_valid", 64'(freg_req_valid_o), 64'd0);
    chk("rst_req_data", 64'(freg_req_data_o), 64'd0);
    chk("rst_m_valid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_m_tid", 64'(m_axis_tid), 64'd0);
    chk("rst_drop", 64'(drop_o), 64'd0);
    step();
    rst = 1'b0;
    step();

    // write 0x8A000000 / 0xDEADBEEF, tid 3
    do_txn(1'b1, 6'd5, 32'hDEADBEEF, 5'd3, 0, 0, 1'b0, 32'h0, 0, 1'b0, 25'h0);
    chk("write_req_literal", 64'(req_seen), 64'h45DEADBEEF);
    // read addr 5, tid 7, response 0x12345678
    do_txn(1'b0, 6'd5, 32'h0, 5'd7, 0, 0, 1'b0, 32'h12345678, 0, 1'b0, 25'h0);
    // request and response backpressure
    do_txn(1'b0, 6'd9, 32'h0, 5'd12, 0, 10, 1'b1, 32'hCAFEF00D, 5, 1'b0, 25'h1ABCDE);
    // malformed frames, then a good one
    do_txn(1'b1, 6'd1, 32'h11111111, 5'd2, 1, 0, 1'b0, 32'h0, 0, 1'b0, 25'h0);
    do_txn(1'b0, 6'd2, 32'h22222222, 5'd4, 2, 0, 1'b0, 32'h0, 0, 1'b0, 25'h0);
    do_txn(1'b0, 6'd63, 32'h0, 5'd31, 0, 1, 1'b1, 32'hFFFFFFFF, 0, 1'b0, 25'h0);

    // unsolicited response in HDR
    d0 = drop_cnt; mq.delete();
    rsp_valid = 1'b1; rsp_data = {1'b0, 4'h0, 6'd3, 32'hABCD0123};
    m_ready = 1'b1;
    @(negedge clk);
    chk("unsol_rsp_ready", 64'(freg_rsp_ready_o), 64'd1);
    step(); rsp_valid = 1'b0;
    repeat (3) step();
    chk("unsol_drop", 64'(drop_cnt - d0), 64'd1);
    chk("unsol_no_m", 64'(mq.size()), 64'd0);
    m_ready = 1'b0;

    // reset while waiting for a read response
    send_beat(32'h06000000, 1'b0, 5'd9);
    send_beat(32'h0, 1'b1, 5'd9);
    req_ready = 1'b1; step(); req_ready = 1'b0;
    step();
    @(negedge clk);
    chk("pre_rst_s_tready", 64'(s_axis_tready), 64'd0);
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_s_tready", 64'(s_axis_tready), 64'd1);
    chk("mid_rst_req_valid", 64'(freg_req_valid_o), 64'd0);
    chk("mid_rst_m_valid", 64'(m_axis_tvalid), 64'd0);
    chk("mid_rst_m_data", 64'(m_axis_tdata), 64'd0);
    chk("mid_rst_m_dest", 64'(m_axis_tdest), 64'd0);
    chk("mid_rst_drop", 64'(drop_o), 64'd0);
    mq.delete(); m_ready = 1'b1;
    repeat (4) step();
    chk("mid_rst_no_m", 64'(mq.size()), 64'd0);
    m_ready = 1'b0;

    // randomized traffic
    for (int t = 0; t < 30; t++) begin
      r = $urandom_range(0, 9);
      kind = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      do_txn(1'($urandom), 6'($urandom), $urandom, 5'($urandom), kind,
             $urandom_range(0, 3), 1'($urandom), $urandom, $urandom_range(0, 2),
             1'b1, 25'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
